// File: rtl/hack_computer.sv
// Single-cycle Hack computer: 16-bit CPU with combinational-read instruction ROM
// and data RAM. One instruction retires per clock.

module hack_rom #(
  parameter int DEPTH = 32768
) (
  input  logic        clk,
  input  logic        ld,
  input  logic [14:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic [14:0] addr,
  output logic [15:0] inst
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] _rom [DEPTH];

  // Optional program-load port; the computer ties it off so the array is read-only.
  always_ff @(posedge clk)
    if (ld && (32'(ld_addr) < DEPTH)) _rom[ld_addr[AW-1:0]] <= ld_data;

  assign inst = (32'(addr) < DEPTH) ? _rom[addr[AW-1:0]] : '0;
endmodule

module hack_ram #(
  parameter int DEPTH = 16384
) (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] _ram [DEPTH];
  logic        hit;

  // Addresses past the array read as zero and swallow writes (no aliasing).
  assign hit   = 32'(addr) < DEPTH;
  assign rdata = hit ? _ram[addr[AW-1:0]] : '0;

  always_ff @(posedge clk)
    if (we && hit) _ram[addr[AW-1:0]] <= wdata;
endmodule

module hack_computer #(
  parameter int ROM_DEPTH = 32768,
  parameter int RAM_DEPTH = 16384
) (
  input logic clk,
  input logic reset
);
  logic [15:0] a, d, inst, m, x, y, out;
  logic [14:0] pc;
  logic        is_c, zr, ng, jmp, ram_we, unused_bits;

  hack_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk     (clk),
    .ld      (1'b0),
    .ld_addr ('0),
    .ld_data ('0),
    .addr    (pc),
    .inst    (inst)
  );

  hack_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (a),
    .wdata (out),
    .rdata (m)
  );

  assign is_c        = inst[15];
  assign unused_bits = ^inst[14:13];

  // ALU: c1..c6 = inst[11:6], a-bit = inst[12]
  always_comb begin
    x = inst[11] ? '0 : d;
    if (inst[10]) x = ~x;
    y = inst[12] ? m : a;
    if (inst[9]) y = '0;
    if (inst[8]) y = ~y;
    out = inst[7] ? (x + y) : (x & y);
    if (inst[6]) out = ~out;
  end

  assign zr     = (out == '0);
  assign ng     = out[15];
  assign jmp    = is_c & ((inst[2] & ng) | (inst[1] & zr) | (inst[0] & ~ng & ~zr));
  assign ram_we = is_c & inst[3] & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      a  <= '0;
      d  <= '0;
    end else begin
      if (!is_c) a <= inst;
      else begin
        if (inst[5]) a <= out;
        if (inst[4]) d <= out;
      end
      pc <= jmp ? a[14:0] : pc + 15'd1;
    end
  end
endmodule

// File: tb/tb_hack_computer.sv
// Directed bench for hack_computer: expected values are queued when a scenario is
// set up and popped as each observation is taken.

module tb_hack_computer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  hack_computer dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  logic [15:0] prog[$];

  task automatic push(input string tag, input logic [15:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_t it;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) passed++;
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Raise reset at a falling edge and load the current program into ROM.
  task automatic begin_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < prog.size(); i++) dut.u_rom._rom[i] <= prog[i];
  endtask

  task automatic release_reset(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_add(input logic [15:0] r0, input logic [15:0] r1, input int hold);
    begin_reset();
    dut.u_ram._ram[0] <= r0;
    dut.u_ram._ram[1] <= r1;
    push($sformatf("add_%0d_%0d", r0, r1), r0 + r1);
    push("add_pc_parked", 16'd1);
    release_reset(hold);
    run(50);
    chk(dut.u_ram._ram[2]);
    chk({15'd0, (dut.pc == 15'd6) || (dut.pc == 15'd7)});
  endtask

  task automatic run_mul(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] e);
    begin_reset();
    dut.u_ram._ram[0] <= r0;
    dut.u_ram._ram[1] <= r1;
    dut.u_ram._ram[2] <= 16'hDEAD;
    push($sformatf("mul_%0d_%0d", r0, r1), e);
    release_reset(1);
    run(50);
    chk(dut.u_ram._ram[2]);
  endtask

  // {a, c1..c6} for each comp mnemonic, with D=5, A=3 expected result
  logic [6:0]  alu_code [18] = '{7'b0101010, 7'b0111111, 7'b0111010, 7'b0001100,
                                 7'b0110000, 7'b0001101, 7'b0110001, 7'b0001111,
                                 7'b0110011, 7'b0011111, 7'b0110111, 7'b0001110,
                                 7'b0110010, 7'b0000010, 7'b0010011, 7'b0000111,
                                 7'b0000000, 7'b0010101};
  logic [15:0] alu_exp  [18] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0005,
                                 16'h0003, 16'hFFFA, 16'hFFFC, 16'hFFFB,
                                 16'hFFFD, 16'h0006, 16'h0004, 16'h0004,
                                 16'h0002, 16'h0008, 16'h0002, 16'hFFFE,
                                 16'h0001, 16'h0007};
  string       alu_name [18] = '{"0", "1", "-1", "D", "A", "!D", "!A", "-D", "-A",
                                 "D+1", "A+1", "D-1", "A-1", "D+A", "D-A", "A-D",
                                 "D&A", "D|A"};
  // D=-1, D=0, D=1 as C-instructions with dest D
  logic [15:0] dset     [3]  = '{16'hEE90, 16'hEA90, 16'hEFD0};

  initial begin
    // reset state
    push("rst_pc", 16'h0000);
    push("rst_a", 16'h0000);
    push("rst_d", 16'h0000);
    run(2);
    chk({1'b0, dut.pc});
    chk(dut.a);
    chk(dut.d);

    // RAM[2] = RAM[0] + RAM[1], then park at 6/7
    prog = '{16'h0000, 16'hFC10, 16'h0001, 16'hF090, 16'h0002, 16'hE308,
             16'h0006, 16'hEA87};
    run_add(16'd2, 16'd3, 1);
    run_add(16'd566, 16'd3, 5);
    run_add(16'd5, 16'd5, 5);

    // Multiply: loop counter lives at RAM[10], the loop-head address, so the
    // decrement and the back-branch share one instruction (M=M-1;JGT).
    prog = '{16'h0002, 16'hEA88, 16'h0001, 16'hFC10, 16'h000E, 16'hE302,
             16'h000A, 16'hE308, 16'h0000, 16'hFC10, 16'h0002, 16'hF088,
             16'h000A, 16'hFC89, 16'h000E, 16'hEA87};
    run_mul(16'd2, 16'd3, 16'd6);
    run_mul(16'd566, 16'd3, 16'd1698);
    run_mul(16'd5, 16'd5, 16'd25);

    // ALU sweep: @5; D=A; @3; D=<comp>
    for (int k = 0; k < 18; k++) begin
      prog = '{16'h0005, 16'hEC10, 16'h0003, 16'hE010 | {3'b000, alu_code[k], 6'b000000}};
      begin_reset();
      push({"alu_", alu_name[k]}, alu_exp[k]);
      release_reset(1);
      run(4);
      chk(dut.d);
    end

    // Jumps: D=v; @100; D;jjj
    for (int di = 0; di < 3; di++) begin
      for (int j = 1; j < 8; j++) begin
        logic [2:0] jj;
        logic       taken;
        jj    = 3'(j);
        taken = (jj[2] && di == 0) || (jj[1] && di == 1) || (jj[0] && di == 2);
        prog  = '{dset[di], 16'd100, 16'hE300 | {13'd0, jj}};
        begin_reset();
        push($sformatf("jmp_d%0d_j%0d", di - 1, j), taken ? 16'd100 : 16'd3);
        release_reset(1);
        run(3);
        chk({1'b0, dut.pc});
      end
    end

    // AMD=M+1 with A=7: write lands at old A
    prog = '{16'h0007, 16'hFDF8};
    begin_reset();
    dut.u_ram._ram[7]  <= 16'd9;
    dut.u_ram._ram[10] <= 16'h0055;
    push("amd_ram7", 16'd10);
    push("amd_d", 16'd10);
    push("amd_a", 16'd10);
    push("amd_ram10", 16'h0055);
    release_reset(1);
    run(2);
    chk(dut.u_ram._ram[7]);
    chk(dut.d);
    chk(dut.a);
    chk(dut.u_ram._ram[10]);

    // Out of range: D=1; @16384; D=M (reads 0); M=D+1 (dropped, no alias to RAM[0])
    prog = '{16'hEFD0, 16'h4000, 16'hFC10, 16'hE7C8};
    begin_reset();
    dut.u_ram._ram[0] <= 16'h1234;
    push("oor_read", 16'h0000);
    push("oor_nowrite", 16'h1234);
    release_reset(1);
    run(3);
    chk(dut.d);
    run(1);
    chk(dut.u_ram._ram[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
